door_sequencer: RTL and testbench

Sequencer and arbiter in front of the door controller: shares the door's single `Activate` input among `N_REQ` requesters (wall button, remote, keypad, supervisor) with round-robin fairness. It also issues an automatic close after a hold time and supervises motor start and travel with watchdogs. It sits between the request sources and the door controller, and observes the controller's `Up_M`/`Dn_M` motor outputs and the `Up_Max`/`Dn_Max` sensors.

---
 rtl/door_sequencer.sv | 168 ++++++++++++++++
 tb/tb_door_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/door_sequencer.sv
// -----------------------------------------------------------------------------
// door_sequencer
//   Shares the door controller's single Activate input among N_REQ requesters
//   using round-robin arbitration. Issues an automatic close once the door has
//   been open and idle for HOLD_CYC cycles. Supervises motor start and travel
//   time with watchdogs.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   Req        in   [N_REQ] level requests, each held until granted
//   Up_Max     in   door fully open sensor
//   Dn_Max     in   door fully closed sensor
//   Up_M/Dn_M  in   motor running indications from the door controller
//   Fault_Clr  in   supervisor fault clear (level)
//   Activate   out  one-cycle pulse to the door controller
//   Grant      out  [N_REQ] one-hot, coincident with Activate (0 = auto-close)
//   Busy       out  movement in progress
//   Fault      out  sticky fault flag
// -----------------------------------------------------------------------------
module door_sequencer #(
    parameter int N_REQ      = 4,
    parameter int CNT_W      = 16,
    parameter int HOLD_CYC   = 1000,
    parameter int TRAVEL_MAX = 5000,
    parameter int AUTO_EN    = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] Req,
    input  logic             Up_Max,
    input  logic             Dn_Max,
    input  logic             Up_M,
    input  logic             Dn_M,
    input  logic             Fault_Clr,
    output logic             Activate,
    output logic [N_REQ-1:0] Grant,
    output logic             Busy,
    output logic             Fault
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TRAV_LAST = CNT_W'(TRAVEL_MAX);
    localparam logic [LW-1:0]    LAST_RST  = LW'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_TRAVEL,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] winner_q, winner_d;
    logic [LW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] trav_q, trav_d;
    logic             miss_q, miss_d;   // one start-watchdog cycle already elapsed

    logic             door_open, door_valid, motor_on;
    logic             pick_vld;
    logic [LW-1:0]    pick_idx;
    logic [LW-1:0]    cand;

    assign door_open  = Up_Max & ~Dn_Max;
    assign door_valid = Up_Max ^ Dn_Max;
    assign motor_on   = Up_M | Dn_M;

    // Round-robin pick: first set request starting just after the last winner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = last_q;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last_q) + k) % N_REQ);
            if (!pick_vld && Req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        hold_d   = '0;          // hold counter only survives while counting in IDLE
        trav_d   = trav_q;
        miss_d   = miss_q;
        unique case (state_q)
            S_IDLE: begin
                if (Up_Max && Dn_Max) begin
                    state_d = S_FAULT;
                end else if (door_valid) begin
                    if (pick_vld) begin
                        // A request beats a simultaneous auto-close expiry.
                        winner_d           = '0;
                        winner_d[pick_idx] = 1'b1;
                        last_d             = pick_idx;
                        state_d            = S_ISSUE;
                    end else if (AUTO_EN != 0 && door_open) begin
                        if (hold_q == HOLD_LAST) begin
                            winner_d = '0;
                            state_d  = S_ISSUE;
                        end else begin
                            hold_d = hold_q + CNT_W'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                miss_d  = 1'b0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (motor_on) begin
                    trav_d  = '0;
                    state_d = S_TRAVEL;
                end else if (miss_q) begin
                    state_d = S_FAULT;
                end else begin
                    miss_d = 1'b1;
                end
            end
            S_TRAVEL: begin
                // Motor-off takes priority over watchdog expiry.
                if (!motor_on) begin
                    state_d = S_IDLE;
                end else if (trav_q == TRAV_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    trav_d = trav_q + CNT_W'(1);
                end
            end
            S_FAULT: begin
                if (Fault_Clr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            winner_q <= '0;
            last_q   <= LAST_RST;
            hold_q   <= '0;
            trav_q   <= '0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            trav_q   <= trav_d;
            miss_q   <= miss_d;
        end
    end

    // Outputs decode registered state only.
    assign Activate = (state_q == S_ISSUE);
    assign Grant    = (state_q == S_ISSUE) ? winner_q : '0;
    assign Busy     = (state_q == S_ISSUE) || (state_q == S_WAIT_START) || (state_q == S_TRAVEL);
    assign Fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_door_sequencer.sv
module tb_door_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] Req;
    logic       Up_Max, Dn_Max, Up_M, Dn_M, Fault_Clr;
    logic       Activate;
    logic [3:0] Grant;
    logic       Busy, Fault;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    door_sequencer #(
        .N_REQ(4), .CNT_W(16), .HOLD_CYC(8), .TRAVEL_MAX(10), .AUTO_EN(1)
    ) dut (
        .CLK(CLK), .RST(RST), .Req(Req),
        .Up_Max(Up_Max), .Dn_Max(Dn_Max), .Up_M(Up_M), .Dn_M(Dn_M),
        .Fault_Clr(Fault_Clr),
        .Activate(Activate), .Grant(Grant), .Busy(Busy), .Fault(Fault)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk(tag, {25'd0, Activate, Grant, Busy, Fault}, 32'd0);
    endtask

    // Wait (bounded) for Activate, then pop the scoreboard and compare Grant.
    task automatic wait_act(input int budget);
        bit got;
        logic [3:0] e;
        got = 1'b0;
        e   = 4'hf;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (Activate) begin
                got = 1'b1;
                break;
            end
        end
        chk("activate_seen", {31'd0, got}, 32'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("grant", {28'd0, Grant}, {28'd0, e});
        chk("busy_issue", {31'd0, Busy}, 32'd1);
    endtask

    task automatic motor_start(input bit up);
        tick();
        chk("act_one_cycle", {31'd0, Activate}, 32'd0);
        chk("busy_wait", {31'd0, Busy}, 32'd1);
        if (up) Up_M = 1'b1;
        else    Dn_M = 1'b1;
    endtask

    task automatic motor_stop();
        Up_M = 1'b0;
        Dn_M = 1'b0;
        tick();
        chk("busy_idle", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Req = 4'b0000; Up_Max = 1'b0; Dn_Max = 1'b1;
        Up_M = 1'b0; Dn_M = 1'b0; Fault_Clr = 1'b0; RST = 1'b1;
        repeat (2) @(negedge CLK);
        outs_zero("reset_outputs");
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            outs_zero("idle_closed_quiet");
        end

        // Round-robin with 1010 held.
        Req = 4'b1010;
        exp_q.push_back(4'b0010); wait_act(5); motor_start(1); repeat (3) tick(); motor_stop();
        exp_q.push_back(4'b1000); wait_act(3); motor_start(1); repeat (3) tick(); motor_stop();
        exp_q.push_back(4'b0010); wait_act(3); Req = 4'b0000;
        motor_start(1); repeat (3) tick(); motor_stop();

        // Auto-close: door opens now, Activate exactly 8 cycles later.
        Up_Max = 1'b1; Dn_Max = 1'b0;
        exp_q.push_back(4'b0000);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("hold_quiet", {31'd0, Activate}, 32'd0);
        end
        wait_act(1);
        motor_start(0); repeat (3) tick();
        Up_Max = 1'b0; Dn_Max = 1'b1;
        motor_stop();
        repeat (2) tick();

        // Request arriving in the expiry cycle wins.
        Up_Max = 1'b1; Dn_Max = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("hold_quiet2", {31'd0, Activate}, 32'd0);
        end
        Req = 4'b0100;
        exp_q.push_back(4'b0100); wait_act(1); Req = 4'b0000;
        motor_start(0); repeat (3) tick();
        Up_Max = 1'b0; Dn_Max = 1'b1;
        motor_stop();

        // Start watchdog: motor never starts.
        Req = 4'b0001;
        exp_q.push_back(4'b0001); wait_act(3); Req = 4'b0000;
        tick(); chk("start_wd_c1", {31'd0, Fault}, 32'd0);
        tick(); chk("start_wd_c2", {31'd0, Fault}, 32'd0);
        tick(); chk("fault_start", {31'd0, Fault}, 32'd1);
        chk("fault_not_busy", {31'd0, Busy}, 32'd0);
        Req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fault_ignores_req", {31'd0, Activate}, 32'd0);
            chk("fault_sticky", {31'd0, Fault}, 32'd1);
        end
        Req = 4'b0000; Fault_Clr = 1'b1;
        tick();
        chk("fault_cleared", {31'd0, Fault}, 32'd0);
        Fault_Clr = 1'b0;
        tick();

        // Travel watchdog: motor stuck on.
        Req = 4'b0010;
        exp_q.push_back(4'b0010); wait_act(3); Req = 4'b0000;
        motor_start(1);
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("travel_running", {31'd0, Fault}, 32'd0);
        end
        tick();
        chk("fault_travel", {31'd0, Fault}, 32'd1);
        Up_M = 1'b0; Fault_Clr = 1'b1;
        tick();
        chk("fault_cleared2", {31'd0, Fault}, 32'd0);
        Fault_Clr = 1'b0;

        // Motor-off in the watchdog expiry cycle goes to IDLE.
        Req = 4'b0100;
        exp_q.push_back(4'b0100); wait_act(3); Req = 4'b0000;
        motor_start(1);
        repeat (11) tick();
        motor_stop();
        chk("race_no_fault", {31'd0, Fault}, 32'd0);

        // Both sensors high in IDLE.
        Up_Max = 1'b1;
        tick();
        chk("fault_sensors", {31'd0, Fault}, 32'd1);
        Up_Max = 1'b0; Fault_Clr = 1'b1;
        tick();
        Fault_Clr = 1'b0;
        chk("fault_cleared3", {31'd0, Fault}, 32'd0);

        // Asynchronous reset during travel, pointer returns to reset value.
        Req = 4'b1000;
        exp_q.push_back(4'b1000); wait_act(3); Req = 4'b0000;
        motor_start(1); repeat (3) tick();
        chk("busy_travel", {31'd0, Busy}, 32'd1);
        RST = 1'b1;
        #1;
        outs_zero("async_reset");
        Up_M = 1'b0;
        tick();
        RST = 1'b0;
        Req = 4'b1111;
        exp_q.push_back(4'b0001); wait_act(3); Req = 4'b0000;
        motor_start(1); repeat (2) tick(); motor_stop();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
